// File: rtl/sr_omega_slew_limiter.sv
// -----------------------------------------------------------------------------
// sr_omega_slew_limiter
//   Per-harmonic slew limiter between the SR frequency-drift generator and the
//   SR oscillator bank. Each update snapshots the packed omega_dt targets and
//   the step size. It then walks the harmonics one per clock through a single
//   shared subtract/compare datapath. Each output moves toward its target by
//   at most slew_step, so oscillator frequency never jumps.
//
//   Optional feature macro: SR_SLEW_STATS_EN. When it is defined, the design
//   builds the saturating clip counter. When it is undefined, clip_count is
//   tied to zero.
//
// Ports
//   clk                  in   system clock
//   rst                  in   asynchronous active-high reset
//   clk_en               in   update request strobe
//   omega_target_packed  in   signed targets, harmonic k at [k*WIDTH +: WIDTH]
//   slew_step            in   unsigned max change per update (0 = hold)
//   omega_out_packed     out  signed slew-limited omega_dt, same packing
//   at_target            out  bit k set when out[k] equals its snapshot target
//   busy                 out  high while an update is in flight
//   update_done          out  one-cycle pulse after the last harmonic write
//   clip_count           out  saturating count of clipped harmonic steps
// -----------------------------------------------------------------------------
module sr_omega_slew_limiter #(
   parameter int WIDTH         = 18,
   parameter int FRAC          = 14,
   parameter int NUM_HARMONICS = 5
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clk_en,
   input  logic [NUM_HARMONICS*WIDTH-1:0]   omega_target_packed,
   input  logic [WIDTH-1:0]                 slew_step,
   output logic [NUM_HARMONICS*WIDTH-1:0]   omega_out_packed,
   output logic [NUM_HARMONICS-1:0]         at_target,
   output logic                             busy,
   output logic                             update_done,
   output logic [15:0]                      clip_count
);

   localparam int IDX_W = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
   // Two guard bits: one for the tgt-out difference, one for out+step.
   localparam int EXT_W = WIDTH + 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HARMONICS - 1);

   // FRAC only documents the Q format; the arithmetic is scale-free.
   if (FRAC > WIDTH) begin : g_frac_out_of_range
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                   state_r, state_nxt_s;
   logic [WIDTH-1:0]         tgt_r [NUM_HARMONICS];
   logic [WIDTH-1:0]         out_r [NUM_HARMONICS];
   logic [NUM_HARMONICS-1:0] at_target_r;
   logic [WIDTH-1:0]         step_r;
   logic [IDX_W-1:0]         idx_r;
   logic                     primed_r, pending_r, busy_r, update_done_r;
   logic                     start_s, write_s, pending_nxt_s, last_s;

   logic [WIDTH-1:0]         cur_s, tgt_s, new_s;
   logic signed [EXT_W-1:0]  cur_x_s, tgt_x_s, step_x_s, diff_s;
   logic                     up_s, dn_s;

   // Clamp a guard-extended value back into the signed WIDTH range.
   function automatic logic [WIDTH-1:0] sat_word(input logic signed [EXT_W-1:0] v);
      logic signed [EXT_W-1:0] max_v;
      logic signed [EXT_W-1:0] min_v;
      max_v = {{3{1'b0}}, {(WIDTH-1){1'b1}}};
      min_v = {{3{1'b1}}, {(WIDTH-1){1'b0}}};
      if (v > max_v) begin
         sat_word = max_v[WIDTH-1:0];
      end else if (v < min_v) begin
         sat_word = min_v[WIDTH-1:0];
      end else begin
         sat_word = v[WIDTH-1:0];
      end
   endfunction

   assign last_s = (idx_r == LAST_IDX);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state, snapshot/write strobes and single-entry request queue.
   always_comb begin
      state_nxt_s   = state_r;
      start_s       = 1'b0;
      write_s       = 1'b0;
      pending_nxt_s = pending_r;
      case (state_r)
         ST_IDLE: begin
            // A request left in pending by the DONE cycle is served here too.
            if (clk_en || pending_r) begin
               start_s       = 1'b1;
               pending_nxt_s = 1'b0;
               state_nxt_s   = ST_SCAN;
            end else begin
               state_nxt_s   = ST_IDLE;
            end
         end
         ST_SCAN: begin
            write_s = 1'b1;
            if (clk_en) begin
               pending_nxt_s = 1'b1;
            end else begin
               pending_nxt_s = pending_r;
            end
            if (last_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SCAN;
            end
         end
         ST_DONE: begin
            if (pending_r) begin
               // The fresh snapshot absorbs any strobe arriving on this edge.
               start_s       = 1'b1;
               pending_nxt_s = 1'b0;
               state_nxt_s   = ST_SCAN;
            end else begin
               pending_nxt_s = clk_en;
               state_nxt_s   = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            pending_nxt_s = 1'b0;
         end
      endcase
   end

   // Shared datapath: step the harmonic selected by idx toward its target.
   always_comb begin
      cur_s    = out_r[idx_r];
      tgt_s    = tgt_r[idx_r];
      cur_x_s  = {{2{cur_s[WIDTH-1]}}, cur_s};
      tgt_x_s  = {{2{tgt_s[WIDTH-1]}}, tgt_s};
      step_x_s = {2'b00, step_r};
      diff_s   = tgt_x_s - cur_x_s;
      up_s     = (diff_s > step_x_s);
      dn_s     = (diff_s < -step_x_s);
      if (!primed_r) begin
         new_s = tgt_s;
      end else if (up_s) begin
         new_s = sat_word(cur_x_s + step_x_s);
      end else if (dn_s) begin
         new_s = sat_word(cur_x_s - step_x_s);
      end else begin
         new_s = tgt_s;
      end
   end

   // Control registers: index, pending request, busy, done pulse, primed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_r         <= '0;
         pending_r     <= 1'b0;
         busy_r        <= 1'b0;
         update_done_r <= 1'b0;
         primed_r      <= 1'b0;
      end else begin
         pending_r     <= pending_nxt_s;
         update_done_r <= write_s && last_s;
         if (start_s) begin
            idx_r  <= '0;
            busy_r <= 1'b1;
         end else if (write_s) begin
            idx_r  <= last_s ? '0 : idx_r + 1'b1;
         end else if (state_r == ST_DONE) begin
            busy_r <= 1'b0;
         end
         if (state_r == ST_DONE) begin
            primed_r <= 1'b1;
         end
      end
   end

   // Snapshot of targets and step, taken once per update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_r <= '0;
         for (int k = 0; k < NUM_HARMONICS; k++) begin
            tgt_r[k] <= '0;
         end
      end else if (start_s) begin
         step_r <= slew_step;
         for (int k = 0; k < NUM_HARMONICS; k++) begin
            tgt_r[k] <= omega_target_packed[k*WIDTH +: WIDTH];
         end
      end
   end

   // Output registers, one harmonic written per SCAN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         at_target_r <= '0;
         for (int k = 0; k < NUM_HARMONICS; k++) begin
            out_r[k] <= '0;
         end
      end else if (write_s) begin
         out_r[idx_r]       <= new_s;
         at_target_r[idx_r] <= (new_s == tgt_s);
      end
   end

`ifdef SR_SLEW_STATS_EN
   logic [15:0] clip_cnt_r;

   // Saturating count of writes that had to be slew-limited.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clip_cnt_r <= 16'd0;
      end else if (write_s && primed_r && (up_s || dn_s) && (clip_cnt_r != 16'hFFFF)) begin
         clip_cnt_r <= clip_cnt_r + 16'd1;
      end
   end

   assign clip_count = clip_cnt_r;
`else
   assign clip_count = 16'd0;
`endif

   for (genvar g = 0; g < NUM_HARMONICS; g++) begin : g_pack
      assign omega_out_packed[g*WIDTH +: WIDTH] = out_r[g];
   end

   assign at_target   = at_target_r;
   assign busy        = busy_r;
   assign update_done = update_done_r;

endmodule

// File: tb/tb_sr_omega_slew_limiter.sv
// -----------------------------------------------------------------------------
// tb_sr_omega_slew_limiter
//   Directed bench for sr_omega_slew_limiter (WIDTH=18, NUM_HARMONICS=5).
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sr_omega_slew_limiter;

   localparam int W = 18;
   localparam int N = 5;

   logic           clk = 1'b0;
   logic           rst;
   logic           clk_en;
   logic [N*W-1:0] omega_target_packed;
   logic [W-1:0]   slew_step;
   logic [N*W-1:0] omega_out_packed;
   logic [N-1:0]   at_target;
   logic           busy;
   logic           update_done;
   logic [15:0]    clip_count;

   int tests = 0;
   int fails = 0;
   int lat;
   int exp_clip = 0;

   sr_omega_slew_limiter #(.WIDTH(W), .FRAC(14), .NUM_HARMONICS(N)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .clk_en              (clk_en),
      .omega_target_packed (omega_target_packed),
      .slew_step           (slew_step),
      .omega_out_packed    (omega_out_packed),
      .at_target           (at_target),
      .busy                (busy),
      .update_done         (update_done),
      .clip_count          (clip_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic longint out_k(input int k);
      logic signed [W-1:0] v;
      v = omega_out_packed[k*W +: W];
      return longint'(v);
   endfunction

   task automatic set_tgt(input int k, input int v);
      omega_target_packed[k*W +: W] = W'(v);
   endtask

   // One clk_en strobe; lat = falling edges from strobe until update_done seen.
   task automatic do_update();
      lat = 99;
      @(negedge clk);
      clk_en = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         clk_en = 1'b0;
         if (update_done && lat == 99) lat = i;
      end
   endtask

   int exp_up [4] = '{203, 207, 211, 212};
   int exp_dn [4] = '{208, 204, 200, 199};
   int base   [5] = '{199, 354, 514, 643, 823};
   int done_first, done_second, done_cnt, busy_low;

   initial begin
      rst                 = 1'b1;
      clk_en              = 1'b0;
      omega_target_packed = '0;
      slew_step           = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_out0", out_k(0), 0);
      check("rst_out4", out_k(4), 0);
      check("rst_at_target", at_target, 0);
      check("rst_busy", busy, 0);
      check("rst_done", update_done, 0);
      check("rst_clip", clip_count, 0);

      // First load: targets copied directly
      for (int k = 0; k < N; k++) set_tgt(k, base[k]);
      slew_step = 18'd4;
      do_update();
      check("load_latency", lat, 6);
      for (int k = 0; k < N; k++) check($sformatf("load_out%0d", k), out_k(k), base[k]);
      check("load_at_target", at_target, 5'b11111);
      check("load_busy_idle", busy, 0);
      check("load_clip", clip_count, 0);

      // Rise 199 -> 212 in steps of 4
      set_tgt(0, 212);
      for (int s = 0; s < 4; s++) begin
         do_update();
         check($sformatf("rise_out0_%0d", s), out_k(0), exp_up[s]);
         check($sformatf("rise_at0_%0d", s), at_target[0], (s == 3) ? 1 : 0);
      end
      check("rise_out3_kept", out_k(3), 643);
      check("rise_at_others", at_target[4:1], 4'b1111);
`ifdef SR_SLEW_STATS_EN
      exp_clip = 3;
`endif
      check("rise_clip", clip_count, exp_clip);

      // Step 0 holds the output even with a distant target
      set_tgt(0, 199);
      slew_step = 18'd0;
      do_update();
      check("hold_out0", out_k(0), 212);
      check("hold_at0", at_target[0], 0);
`ifdef SR_SLEW_STATS_EN
      exp_clip = 4;
`endif
      check("hold_clip", clip_count, exp_clip);

      // Fall 212 -> 199 in steps of 4
      slew_step = 18'd4;
      for (int s = 0; s < 4; s++) begin
         do_update();
         check($sformatf("fall_out0_%0d", s), out_k(0), exp_dn[s]);
      end
      check("fall_at_target", at_target, 5'b11111);
`ifdef SR_SLEW_STATS_EN
      exp_clip = 7;
`endif
      check("fall_clip", clip_count, exp_clip);

      // Overlap: two strobes during SCAN give one back-to-back update
      done_first = 0; done_second = 0; done_cnt = 0; busy_low = 0;
      @(negedge clk);
      clk_en = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         clk_en = (i == 2 || i == 4) ? 1'b1 : 1'b0;
         if (update_done) begin
            done_cnt++;
            if (done_first == 0) done_first = i;
            else if (done_second == 0) done_second = i;
         end
         if (i <= 12 && !busy) busy_low++;
      end
      check("ovl_done_pulses", done_cnt, 2);
      check("ovl_first_done", done_first, 6);
      check("ovl_second_done", done_second, 12);
      check("ovl_busy_gap", busy_low, 0);
      check("ovl_busy_end", busy, 0);

      // Reset mid-SCAN, then a direct (unslewed) reload
      @(negedge clk);
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_out0", out_k(0), 0);
      check("mid_rst_out4", out_k(4), 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_at_target", at_target, 0);
      @(negedge clk);
      rst = 1'b0;
      set_tgt(0, 150);
      do_update();
      check("reload_latency", lat, 6);
      check("reload_out0", out_k(0), 150);
      check("reload_out4", out_k(4), 823);
      check("reload_at_target", at_target, 5'b11111);
      check("reload_clip", clip_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
